// File: rtl/ppu_defines.sv
// rtl/ppu_defines.sv - shared PPU/VGA line buffer constants and types
package ppu_defines;

    localparam int LINE_PIXELS = 256;
    localparam int IDX_W = 8;
    localparam int COLOR_W = 6;
    localparam logic [5:0] BLANK_COLOR = 6'h0f;

    typedef logic vga_bank_t;

endpackage

// File: rtl/line_buf_ram.sv
// rtl/line_buf_ram.sv - two-bank scanline RAM, one write port and one registered read port
module line_buf_ram #(
    parameter int LINE_PIXELS = ppu_defines::LINE_PIXELS,
    parameter int IDX_W = ppu_defines::IDX_W,
    parameter int COLOR_W = ppu_defines::COLOR_W
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [IDX_W:0]     wr_addr,
    input  logic [COLOR_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [IDX_W:0]     rd_addr,
    output logic [COLOR_W-1:0] rd_data
);
    import ppu_defines::*;

    // Address is {bank, idx}; the two banks are stacked in one array.
    logic [COLOR_W-1:0] mem [0:2*LINE_PIXELS-1];

    // Write port: contents are never cleared, reset only invalidates banks upstream.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read port, advanced only on enabled ticks.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vga_line_buf_ctrl.sv
// rtl/vga_line_buf_ctrl.sv - ping-pong scanline buffer sequencing between PPU and VGA
module vga_line_buf_ctrl #(
    parameter int REPEAT = 2,
    parameter int LINE_PIXELS = ppu_defines::LINE_PIXELS,
    parameter int IDX_W = ppu_defines::IDX_W,
    parameter int COLOR_W = ppu_defines::COLOR_W,
    parameter logic [COLOR_W-1:0] BLANK_COLOR = COLOR_W'(ppu_defines::BLANK_COLOR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               ppu_pix_wr,
    input  logic [IDX_W-1:0]   ppu_pix_idx,
    input  logic [COLOR_W-1:0] ppu_pix_color,
    input  logic               ppu_line_done,
    output logic               ppu_ready,
    input  logic               vga_frame_start,
    input  logic               vga_line_end,
    input  logic [IDX_W-1:0]   vga_buf_idx,
    output logic [COLOR_W-1:0] vga_buf_out,
    output logic               underrun,
    output logic               overrun,
    input  logic               status_clr
);
    import ppu_defines::*;

    localparam int CNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT - 1);

    vga_bank_t          wr_bank;
    vga_bank_t          rd_bank;
    logic               wr_full;
    logic               rd_valid;
    logic               out_valid;
    logic [CNT_W-1:0]   rep_cnt;
    logic [COLOR_W-1:0] ram_q;

    logic row_end;
    logic row_last;
    logic line_avail;
    logic swap;
    logic underrun_set;
    logic pix_accept;
    logic pix_drop;

    assign rd_bank   = ~wr_bank;
    assign ppu_ready = ~wr_full;

    // Frame start overrides a coincident line end, so only a bare line end advances rows.
    assign row_end      = clk_en & vga_line_end & ~vga_frame_start;
    assign row_last     = (rep_cnt == REP_LAST);
    assign line_avail   = wr_full | ppu_line_done;
    assign swap         = row_end & row_last & line_avail;
    assign underrun_set = row_end & row_last & ~line_avail & rd_valid;
    assign pix_accept   = clk_en & ppu_pix_wr & ~wr_full;
    assign pix_drop     = clk_en & ppu_pix_wr & wr_full;

    line_buf_ram #(
        .LINE_PIXELS (LINE_PIXELS),
        .IDX_W       (IDX_W),
        .COLOR_W     (COLOR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (pix_accept),
        .wr_addr ({wr_bank, ppu_pix_idx}),
        .wr_data (ppu_pix_color),
        .rd_en   (clk_en),
        .rd_addr ({rd_bank, vga_buf_idx}),
        .rd_data (ram_q)
    );

    // Bank swap, row repeat counting, read-valid tracking and sticky status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank   <= 1'b0;
            wr_full   <= 1'b0;
            rd_valid  <= 1'b0;
            out_valid <= 1'b0;
            rep_cnt   <= '0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else if (clk_en) begin
            if (vga_frame_start) begin
                rep_cnt <= '0;
            end else if (vga_line_end) begin
                if (!row_last) begin
                    rep_cnt <= rep_cnt + 1'b1;
                end else if (line_avail) begin
                    rep_cnt <= '0;
                end
            end

            // A pixel on the swap tick has already gone into the outgoing bank,
            // and a line_done on that tick is consumed by the swap itself.
            if (swap) begin
                wr_bank  <= ~wr_bank;
                wr_full  <= 1'b0;
                rd_valid <= 1'b1;
            end else if (ppu_line_done) begin
                wr_full <= 1'b1;
            end

            // Tracks whether the word now in the RAM read register came from a valid bank.
            out_valid <= rd_valid;

            underrun <= underrun_set | (underrun & ~status_clr);
            overrun  <= pix_drop | (overrun & ~status_clr);
        end
    end

    assign vga_buf_out = out_valid ? ram_q : BLANK_COLOR;

endmodule

// File: tb/tb_vga_line_buf_ctrl.sv
// tb/tb_vga_line_buf_ctrl.sv - directed self-checking bench for vga_line_buf_ctrl
module tb_vga_line_buf_ctrl;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       ppu_pix_wr;
    logic [7:0] ppu_pix_idx;
    logic [5:0] ppu_pix_color;
    logic       ppu_line_done;
    logic       ppu_ready;
    logic       vga_frame_start;
    logic       vga_line_end;
    logic [7:0] vga_buf_idx;
    logic [5:0] vga_buf_out;
    logic       underrun;
    logic       overrun;
    logic       status_clr;

    int checks;
    int errors;

    vga_line_buf_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .ppu_pix_wr      (ppu_pix_wr),
        .ppu_pix_idx     (ppu_pix_idx),
        .ppu_pix_color   (ppu_pix_color),
        .ppu_line_done   (ppu_line_done),
        .ppu_ready       (ppu_ready),
        .vga_frame_start (vga_frame_start),
        .vga_line_end    (vga_line_end),
        .vga_buf_idx     (vga_buf_idx),
        .vga_buf_out     (vga_buf_out),
        .underrun        (underrun),
        .overrun         (overrun),
        .status_clr      (status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        ppu_pix_wr      = 1'b0;
        ppu_line_done   = 1'b0;
        vga_frame_start = 1'b0;
        vga_line_end    = 1'b0;
        status_clr      = 1'b0;
    endtask

    task automatic write_pix(input logic [7:0] idx, input logic [5:0] color);
        ppu_pix_wr    = 1'b1;
        ppu_pix_idx   = idx;
        ppu_pix_color = color;
        tick();
        ppu_pix_wr = 1'b0;
    endtask

    task automatic pulse_line_end();
        vga_line_end = 1'b1;
        tick();
        vga_line_end = 1'b0;
    endtask

    task automatic pulse_line_done();
        ppu_line_done = 1'b1;
        tick();
        ppu_line_done = 1'b0;
    endtask

    task automatic pulse_frame_start();
        vga_frame_start = 1'b1;
        tick();
        vga_frame_start = 1'b0;
    endtask

    task automatic pulse_status_clr();
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b1;
        ppu_pix_idx = 8'd0;
        ppu_pix_color = 6'd0;
        vga_buf_idx = 8'd5;
        clear_inputs();

        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_ready", 8'(ppu_ready), 8'h1);
        check("rst_out", 8'(vga_buf_out), 8'h0f);
        check("rst_underrun", 8'(underrun), 8'h0);
        check("rst_overrun", 8'(overrun), 8'h0);

        // Line ends with nothing buffered: blank output, no underrun
        for (int k = 0; k < 3; k++) begin
            pulse_line_end();
            check("empty_out", 8'(vga_buf_out), 8'h0f);
            check("empty_underrun", 8'(underrun), 8'h0);
        end

        // Fill line A with color = idx[5:0]
        for (int i = 0; i < 256; i++) begin
            write_pix(8'(i), 6'(i));
        end
        pulse_line_done();
        check("a_done_ready", 8'(ppu_ready), 8'h0);
        pulse_frame_start();
        pulse_line_end();
        check("a_row0_ready", 8'(ppu_ready), 8'h0);
        pulse_line_end();
        check("a_swap_ready", 8'(ppu_ready), 8'h1);
        check("a_swap_out_blank", 8'(vga_buf_out), 8'h0f);
        tick();
        check("a_idx5", 8'(vga_buf_out), 8'h05);

        // Gated tick ignores line_done
        clk_en = 1'b0;
        ppu_line_done = 1'b1;
        tick();
        ppu_line_done = 1'b0;
        clk_en = 1'b1;
        check("gated_ready", 8'(ppu_ready), 8'h1);

        // Fill line B with color = ~idx[5:0], then a dropped write
        for (int i = 0; i < 256; i++) begin
            write_pix(8'(i), ~6'(i));
        end
        pulse_line_done();
        check("b_done_ready", 8'(ppu_ready), 8'h0);
        write_pix(8'd10, 6'h2a);
        check("overrun_set", 8'(overrun), 8'h1);
        pulse_status_clr();
        check("overrun_clr", 8'(overrun), 8'h0);

        // A shown for exactly two rows, then B
        check("a_still", 8'(vga_buf_out), 8'h05);
        pulse_line_end();
        check("a_row1", 8'(vga_buf_out), 8'h05);
        pulse_line_end();
        check("a_last_read", 8'(vga_buf_out), 8'h05);
        tick();
        check("b_idx5", 8'(vga_buf_out), 8'h3a);
        vga_buf_idx = 8'd10;
        tick();
        check("b_idx10_kept", 8'(vga_buf_out), 8'h35);
        check("b_no_underrun", 8'(underrun), 8'h0);

        // No new line at swap point: B redisplayed, underrun flagged
        pulse_line_end();
        pulse_line_end();
        check("underrun_set", 8'(underrun), 8'h1);
        tick();
        check("b_redisplay", 8'(vga_buf_out), 8'h35);
        status_clr = 1'b1;
        vga_line_end = 1'b1;
        tick();
        clear_inputs();
        check("underrun_set_wins", 8'(underrun), 8'h1);
        pulse_status_clr();
        check("underrun_clr", 8'(underrun), 8'h0);

        // Line C: line_done and a pixel on the swap tick itself
        write_pix(8'd5, 6'h11);
        pulse_frame_start();
        pulse_line_end();
        ppu_line_done = 1'b1;
        vga_line_end = 1'b1;
        ppu_pix_wr = 1'b1;
        ppu_pix_idx = 8'd6;
        ppu_pix_color = 6'h22;
        tick();
        clear_inputs();
        check("c_swap_ready", 8'(ppu_ready), 8'h1);
        check("c_swap_underrun", 8'(underrun), 8'h0);
        vga_buf_idx = 8'd5;
        tick();
        check("c_idx5", 8'(vga_buf_out), 8'h11);
        vga_buf_idx = 8'd6;
        tick();
        check("c_idx6_swap_write", 8'(vga_buf_out), 8'h22);

        // Frame start beats a coincident line end
        write_pix(8'd5, 6'h33);
        pulse_line_done();
        pulse_line_end();
        vga_frame_start = 1'b1;
        vga_line_end = 1'b1;
        tick();
        clear_inputs();
        check("fs_prio_ready", 8'(ppu_ready), 8'h0);
        vga_buf_idx = 8'd5;
        tick();
        check("fs_prio_out", 8'(vga_buf_out), 8'h11);
        pulse_line_end();
        check("fs_row0_ready", 8'(ppu_ready), 8'h0);
        pulse_line_end();
        check("d_swap_ready", 8'(ppu_ready), 8'h1);
        tick();
        check("d_idx5", 8'(vga_buf_out), 8'h33);

        // Reset mid-fill
        write_pix(8'd0, 6'h01);
        write_pix(8'd1, 6'h02);
        ppu_pix_wr = 1'b1;
        ppu_pix_idx = 8'd2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ppu_pix_wr = 1'b0;
        check("midrst_ready", 8'(ppu_ready), 8'h1);
        check("midrst_out", 8'(vga_buf_out), 8'h0f);
        check("midrst_underrun", 8'(underrun), 8'h0);
        pulse_line_end();
        pulse_line_end();
        tick();
        check("midrst_blank", 8'(vga_buf_out), 8'h0f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
